// File: rtl/pj_bus_chk_pkg.sv
// Shared definitions for the picoJava bus checker: error codes, FSM states
// and the expected-ack lookup per transaction type.
package pj_bus_chk_pkg;

   localparam int NUM_CODES        = 8;
   localparam int ERR_STANDBY_TV   = 0;
   localparam int ERR_ILLEGAL_TYPE = 1;
   localparam int ERR_ILLEGAL_SIZE = 2;
   localparam int ERR_SPURIOUS_ACK = 3;
   localparam int ERR_TV_DROP      = 4;
   localparam int ERR_TIMEOUT      = 5;
   localparam int ERR_EXTRA_ACK    = 6;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } txn_state_e;

   // Zero marks an illegal type.
   function automatic logic [2:0] expected_acks(input logic [2:0] txn_type);
      case (txn_type)
         3'b000:                 expected_acks = 3'd2;
         3'b010, 3'b110, 3'b111: expected_acks = 3'd1;
         3'b100, 3'b101:         expected_acks = 3'd4;
         default:                expected_acks = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/pj_bus_checker_if.sv
// picoJava memory-bus signals as seen by the checker; the core side drives
// through master, the checker observes through slave.
interface pj_bus_checker_if #(
   parameter int AW = 30,
   parameter int DW = 32
);
   logic          pj_tv;
   logic [3:0]    pj_type;
   logic [1:0]    pj_size;
   logic [1:0]    pj_ack;
   logic [AW-1:0] pj_address;
   logic [DW-1:0] pj_data_in;
   logic [DW-1:0] pj_data_out;
   logic          pj_standby_out;

   modport master (
      output pj_tv, pj_type, pj_size, pj_ack, pj_address,
             pj_data_in, pj_data_out, pj_standby_out
   );

   modport slave (
      input  pj_tv, pj_type, pj_size, pj_ack, pj_address,
             pj_data_in, pj_data_out, pj_standby_out
   );
endinterface

// File: rtl/pj_bus_chk_txn.sv
// Transaction tracker: IDLE/BUSY FSM with remaining-ack and ack-timeout down-counters.
//   state   | meaning
//   ST_IDLE | no transaction outstanding; legal pj_tv starts one
//   ST_BUSY | waiting for the remaining acks of the latched transaction
module pj_bus_chk_txn
   import pj_bus_chk_pkg::*;
#(
   parameter int AW          = 30,
   parameter int ACK_TIMEOUT = 50
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          tv,
   input  logic [2:0]    txn_type,
   input  logic [1:0]    ack,
   input  logic [AW-1:0] address,
   input  logic          abort,
   output logic          busy,
   output logic          final_ack,
   output logic          timeout,
   output logic          done_q,
   output logic [AW-1:0] lat_addr
);

   localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(ACK_TIMEOUT - 1);

   txn_state_e       state;
   logic [2:0]       rem_cnt;
   logic [TMO_W-1:0] tmo_cnt;
   logic [2:0]       lat_type;
   logic [2:0]       exp_acks;
   logic             start;
   logic [2:0]       unused_lat_type;

   assign exp_acks        = expected_acks(txn_type);
   assign start           = (state == ST_IDLE) && tv && (exp_acks != 3'd0);
   // Error acks terminate the transaction just like the last data ack.
   assign final_ack       = (state == ST_BUSY) &&
                            (ack[1] || (ack == 2'b01 && rem_cnt == 3'd1));
   assign timeout         = (state == ST_BUSY) && (ack == 2'b00) && (tmo_cnt == '0);
   assign unused_lat_type = lat_type;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         busy     <= 1'b0;
         done_q   <= 1'b0;
         rem_cnt  <= '0;
         tmo_cnt  <= '0;
         lat_addr <= '0;
         lat_type <= '0;
      end else begin
         done_q <= final_ack;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_BUSY;
                  busy     <= 1'b1;
                  rem_cnt  <= exp_acks;
                  tmo_cnt  <= TMO_LOAD;
                  lat_addr <= address;
                  lat_type <= txn_type;
               end
            end
            ST_BUSY: begin
               if (final_ack || timeout || abort) begin
                  state   <= ST_IDLE;
                  busy    <= 1'b0;
                  rem_cnt <= '0;
                  tmo_cnt <= '0;
               end else if (ack == 2'b01) begin
                  rem_cnt <= rem_cnt - 3'd1;
                  tmo_cnt <= TMO_LOAD;
               end else begin
                  tmo_cnt <= tmo_cnt - TMO_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/pj_bus_checker.sv
// picoJava bus protocol checker: per-cycle rule checks, lowest-code
// reporting, sticky flags and a saturating error counter.
module pj_bus_checker
   import pj_bus_chk_pkg::*;
#(
   parameter int AW          = 30,
   parameter int DW          = 32,
   parameter int ACK_TIMEOUT = 50,
   parameter int CNT_W       = 16
)(
   input  logic             clk,
   input  logic             reset,
   pj_bus_checker_if.slave  bus,
   input  logic             err_clr,
   output logic             err_valid,
   output logic [3:0]       err_code,
   output logic [AW-1:0]    err_addr,
   output logic [7:0]       err_sticky,
   output logic [CNT_W-1:0] err_count,
   output logic             txn_active
);

   logic                 final_ack;
   logic                 timeout;
   logic                 done_q;
   logic                 tv_drop;
   logic                 type_legal;
   logic                 any_err;
   logic [AW-1:0]        lat_addr;
   logic [NUM_CODES-1:0] errs;
   logic [3:0]           code_nxt;
   logic [AW-1:0]        addr_nxt;
   logic [DW-1:0]        unused_data;
   logic                 unused_type_msb;

   assign type_legal      = expected_acks(bus.pj_type[2:0]) != 3'd0;
   assign tv_drop         = txn_active && !bus.pj_tv && !final_ack;
   assign unused_data     = bus.pj_data_in ^ bus.pj_data_out;
   assign unused_type_msb = bus.pj_type[3];

   pj_bus_chk_txn #(
      .AW          (AW),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) u_txn (
      .clk       (clk),
      .reset     (reset),
      .tv        (bus.pj_tv),
      .txn_type  (bus.pj_type[2:0]),
      .ack       (bus.pj_ack),
      .address   (bus.pj_address),
      .abort     (tv_drop),
      .busy      (txn_active),
      .final_ack (final_ack),
      .timeout   (timeout),
      .done_q    (done_q),
      .lat_addr  (lat_addr)
   );

   always_comb begin
      errs                   = '0;
      errs[ERR_STANDBY_TV]   = bus.pj_tv && bus.pj_standby_out;
      errs[ERR_ILLEGAL_TYPE] = bus.pj_tv && !type_legal;
      errs[ERR_ILLEGAL_SIZE] = bus.pj_tv && (bus.pj_size == 2'b11);
      errs[ERR_SPURIOUS_ACK] = !txn_active && (bus.pj_ack != 2'b00);
      errs[ERR_TV_DROP]      = tv_drop;
      errs[ERR_TIMEOUT]      = timeout;
      // Ack right after the final one with tv still up and nothing new started;
      // always coincides with SPURIOUS_ACK, which wins on priority.
      errs[ERR_EXTRA_ACK]    = done_q && !txn_active && bus.pj_tv && !type_legal &&
                               (bus.pj_ack == 2'b01);
   end

   assign any_err = |errs;

   always_comb begin
      code_nxt = '0;
      for (int i = NUM_CODES - 1; i >= 0; i--) begin
         if (errs[i]) code_nxt = 4'(i);
      end
   end

   assign addr_nxt = (code_nxt == 4'(ERR_TV_DROP) || code_nxt == 4'(ERR_TIMEOUT)) ?
                     lat_addr : bus.pj_address;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_valid  <= 1'b0;
         err_code   <= '0;
         err_addr   <= '0;
         err_sticky <= '0;
         err_count  <= '0;
      end else begin
         err_valid <= any_err;
         if (any_err) begin
            err_code <= code_nxt;
            err_addr <= addr_nxt;
         end
         if (err_clr) begin
            err_sticky <= errs;
            err_count  <= {{(CNT_W-1){1'b0}}, any_err};
         end else begin
            err_sticky <= err_sticky | errs;
            if (any_err && err_count != '1)
               err_count <= err_count + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: tb/tb_pj_bus_checker.sv
// Directed bench for pj_bus_checker with hand-computed expectations.
module tb_pj_bus_checker;

   localparam int AW    = 30;
   localparam int DW    = 32;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             err_clr = 1'b0;
   logic             err_valid;
   logic [3:0]       err_code;
   logic [AW-1:0]    err_addr;
   logic [7:0]       err_sticky;
   logic [CNT_W-1:0] err_count;
   logic             txn_active;

   int n_checks = 0;
   int n_fail   = 0;
   int busy_cycles;
   int err_seen;

   pj_bus_checker_if #(.AW(AW), .DW(DW)) bus ();

   pj_bus_checker #(
      .AW          (AW),
      .DW          (DW),
      .ACK_TIMEOUT (50),
      .CNT_W       (CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .err_clr    (err_clr),
      .err_valid  (err_valid),
      .err_code   (err_code),
      .err_addr   (err_addr),
      .err_sticky (err_sticky),
      .err_count  (err_count),
      .txn_active (txn_active)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic tv, input logic [3:0] typ, input logic [1:0] size,
                        input logic [1:0] ack, input logic [AW-1:0] addr);
      bus.pj_tv      = tv;
      bus.pj_type    = typ;
      bus.pj_size    = size;
      bus.pj_ack     = ack;
      bus.pj_address = addr;
   endtask

   task automatic idle();
      drive(1'b0, 4'h0, 2'b00, 2'b00, '0);
      bus.pj_standby_out = 1'b0;
      err_clr            = 1'b0;
   endtask

   initial begin
      idle();
      bus.pj_data_in  = 32'hCAFE_0001;
      bus.pj_data_out = 32'h1234_5678;

      step();
      step();
      check("rst_valid",  err_valid,  0);
      check("rst_code",   err_code,   0);
      check("rst_addr",   err_addr,   0);
      check("rst_sticky", err_sticky, 0);
      check("rst_count",  err_count,  0);
      check("rst_active", txn_active, 0);
      reset = 1'b0;
      step();
      check("idle_valid", err_valid, 0);

      // Type 100, four consecutive data acks.
      busy_cycles = 0;
      err_seen    = 0;
      drive(1'b1, 4'b0100, 2'b10, 2'b00, 30'h0000_1A00);
      step();
      busy_cycles += int'(txn_active);
      err_seen    += int'(err_valid);
      for (int i = 0; i < 4; i++) begin
         bus.pj_ack = 2'b01;
         step();
         busy_cycles += int'(txn_active);
         err_seen    += int'(err_valid);
      end
      check("t100_busy_cycles", busy_cycles, 4);
      check("t100_no_err",      err_seen,    0);
      check("t100_done",        txn_active,  0);

      // Type 110 single ack, back-to-back type 010 ended by an IO-error ack.
      drive(1'b1, 4'b0110, 2'b10, 2'b00, 30'h0000_2B00);
      step();
      bus.pj_ack = 2'b01;
      step();
      check("t110_done", txn_active, 0);
      drive(1'b1, 4'b0010, 2'b10, 2'b00, 30'h0000_2C00);
      step();
      check("b2b_start", txn_active, 1);
      check("b2b_no_err", err_valid, 0);
      bus.pj_ack = 2'b11;
      step();
      check("ioerr_ack_idle",   txn_active, 0);
      check("ioerr_ack_no_err", err_valid,  0);
      check("clean_sticky",     err_sticky, 0);
      idle();
      step();

      // Illegal type and illegal size together.
      drive(1'b1, 4'b0011, 2'b11, 2'b00, 30'h0000_3C00);
      step();
      check("ill_valid",  err_valid,  1);
      check("ill_code",   err_code,   1);
      check("ill_addr",   err_addr,   30'h0000_3C00);
      check("ill_sticky", err_sticky, 8'h06);
      check("ill_count",  err_count,  1);
      check("ill_active", txn_active, 0);
      idle();
      step();
      check("pulse_one_cycle", err_valid, 0);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("clr_sticky", err_sticky, 0);
      check("clr_count",  err_count,  0);

      // Spurious ack, then a second one under err_clr.
      drive(1'b0, 4'h0, 2'b00, 2'b01, 30'h0000_4D00);
      step();
      check("spur_code",   err_code,   3);
      check("spur_addr",   err_addr,   30'h0000_4D00);
      check("spur_sticky", err_sticky, 8'h08);
      check("spur_count",  err_count,  1);
      err_clr = 1'b1;
      step();
      check("spur_clr_valid",  err_valid,  1);
      check("spur_clr_sticky", err_sticky, 8'h08);
      check("spur_clr_count",  err_count,  1);
      idle();
      step();

      // pj_tv dropped mid type 000 transaction.
      drive(1'b1, 4'b0000, 2'b10, 2'b00, 30'h0000_5E00);
      step();
      bus.pj_ack = 2'b01;
      step();
      drive(1'b0, 4'b0000, 2'b10, 2'b00, 30'h0000_5F00);
      step();
      check("drop_valid",  err_valid,  1);
      check("drop_code",   err_code,   4);
      check("drop_addr",   err_addr,   30'h0000_5E00);
      check("drop_sticky", err_sticky, 8'h18);
      check("drop_count",  err_count,  2);
      check("drop_idle",   txn_active, 0);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;

      // Type 000 with one ack, then 50 silent cycles.
      drive(1'b1, 4'b0000, 2'b10, 2'b00, 30'h0000_6A00);
      step();
      bus.pj_ack = 2'b01;
      step();
      bus.pj_ack     = 2'b00;
      bus.pj_address = 30'h0000_6B00;
      err_seen    = 0;
      busy_cycles = 0;
      for (int i = 0; i < 49; i++) begin
         step();
         err_seen    += int'(err_valid);
         busy_cycles += int'(txn_active);
      end
      check("tmo_not_early", err_seen,    0);
      check("tmo_busy_wait", busy_cycles, 49);
      step();
      check("tmo_valid",  err_valid,  1);
      check("tmo_code",   err_code,   5);
      check("tmo_addr",   err_addr,   30'h0000_6A00);
      check("tmo_sticky", err_sticky, 8'h20);
      check("tmo_count",  err_count,  1);
      check("tmo_idle",   txn_active, 0);
      idle();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;

      // Standby tv starts a type 101 transaction; reset lands mid-transaction.
      drive(1'b1, 4'b0101, 2'b01, 2'b00, 30'h0000_7C00);
      bus.pj_standby_out = 1'b1;
      step();
      check("stby_code",   err_code,   0);
      check("stby_addr",   err_addr,   30'h0000_7C00);
      check("stby_sticky", err_sticky, 8'h01);
      check("stby_active", txn_active, 1);
      bus.pj_standby_out = 1'b0;
      bus.pj_ack         = 2'b01;
      step();
      check("t101_busy",   txn_active, 1);
      check("t101_no_err", err_valid,  0);
      #2;
      reset = 1'b1;
      idle();
      #1;
      check("mid_rst_active", txn_active, 0);
      check("mid_rst_sticky", err_sticky, 0);
      check("mid_rst_count",  err_count,  0);
      check("mid_rst_code",   err_code,   0);
      check("mid_rst_addr",   err_addr,   0);
      step();
      reset = 1'b0;
      err_seen = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         err_seen += int'(err_valid) + int'(txn_active);
      end
      check("post_rst_quiet",  err_seen,   0);
      check("post_rst_sticky", err_sticky, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pj_bus_checker.md
PJ_BUS_CHECKER -- requirements
Module: pj_bus_checker

Interface
REQ-001 Parameter AW, default 30: width of the word address bus.
REQ-002 Parameter DW, default 32: width of the data buses.
REQ-003 Parameter ACK_TIMEOUT, default 50: number of BUSY cycles without any ack before a timeout error.
REQ-004 Parameter CNT_W, default 16: width of the error counter.
REQ-005 Port list (name, direction, width, meaning):
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- pj_tv  in  1  transaction valid.
- pj_type  in  4  transaction type; bits [2:0] are decoded.
- pj_size  in  2  transfer size.
- pj_ack  in  2  00 none, 01 data ack, 10 memory-error ack, 11 IO-error ack.
- pj_address  in  AW  transaction address.
- pj_data_in  in  DW  load data; monitored only, never checked.
- pj_data_out  in  DW  store data; monitored only, never checked.
- pj_standby_out  in  1  core is in standby.
- err_clr  in  1  clears the sticky flags and the error counter.
- err_valid  out  1  one-cycle pulse when an error is detected.
- err_code  out  4  code of the reported error.
- err_addr  out  AW  transaction address captured with the error.
- err_sticky  out  8  one bit per error code, set and held.
- err_count  out  CNT_W  saturating count of errors.
- txn_active  out  1  high while the FSM is in BUSY.

Function
REQ-006 Expected acks per pj_type[2:0]: 000→2, 010→1, 100→4, 101→4, 110→1, 111→1; 001 and 011 are illegal.
REQ-007 The FSM shall have two states, IDLE and BUSY.
REQ-008 IDLE → BUSY when pj_tv=1 and the type is legal; the block latches the remaining-ack count, the type and the address.
REQ-009 In BUSY, each pj_ack=01 decrements the remaining count and clears the timeout counter.
REQ-010 On the ack that brings the count to 0, the FSM returns to IDLE on the same clock edge.
REQ-011 In BUSY, pj_ack=10 or 11 terminates the transaction: FSM → IDLE, no error is flagged, and the ack is counted as the final ack.
REQ-012 Timeout counter: increments every BUSY cycle with pj_ack=00; on reaching ACK_TIMEOUT it raises TIMEOUT and the FSM → IDLE.
REQ-013 Checks performed every cycle, with their codes:
- 0 STANDBY_TV: pj_tv=1 and pj_standby_out=1.
- 1 ILLEGAL_TYPE: pj_tv=1 and pj_type[2:0] is 001 or 011.
- 2 ILLEGAL_SIZE: pj_tv=1 and pj_size=11.
- 3 SPURIOUS_ACK: pj_ack≠00 in IDLE.
- 4 TV_DROP: pj_tv=0 in BUSY before the final ack.
- 5 TIMEOUT: as defined in REQ-012.
- 6 EXTRA_ACK: pj_ack=01 in the same cycle as the final ack's successor while pj_tv remains high with no new transaction; this case is reported as SPURIOUS_ACK when the FSM is in IDLE.
REQ-014 TV_DROP shall force the FSM → IDLE.
REQ-015 Simultaneous errors: err_code reports the lowest code; every detected error sets its own sticky bit; err_count increments by 1 per cycle.
REQ-016 err_valid, err_code and err_addr are registered, one cycle after the offending sampled inputs.
REQ-017 err_addr is the latched BUSY address for codes 4 and 5, and pj_address for all other codes.
REQ-018 err_count saturates at all-ones.
REQ-019 err_clr clears err_sticky and err_count; if an error occurs in the same cycle, the new error's bit is set and the count loads 1.
REQ-020 Back-to-back transactions: if pj_tv=1 in the cycle after the final ack, it starts a new transaction from IDLE.

Reset
REQ-021 While reset=1, the FSM is IDLE and all counters are 0.
REQ-022 While reset=1, err_valid=0, err_code=0, err_addr=0, err_sticky=0, err_count=0 and txn_active=0.
REQ-023 Reset asserted mid-transaction shall abandon the transaction and flag no error.

Structure
REQ-024 Package pj_bus_chk_pkg shall hold the error-code constants, the FSM state enum, and the expected-ack lookup function.
REQ-025 Sub-module pj_bus_chk_txn shall contain the FSM, the ack counter and the timeout counter; the top level contains the checks, prioritisation and error registers.

Verification
REQ-026 Type 100, pj_tv held, four 01 acks on consecutive cycles → txn_active for 4 cycles, no err_valid.
REQ-027 Type 000 with a single ack, then no further ack for 50 cycles → err_code=5, err_addr equals the latched address, err_sticky[5]=1.
REQ-028 pj_tv=1 with pj_type=0011 and pj_size=11 in the same cycle → err_code=1, err_sticky bits 1 and 2 set, err_count=1.
REQ-029 pj_ack=01 in IDLE → err_code=3; err_clr applied in the same cycle as a second spurious ack → err_sticky=0x08, err_count=1.
REQ-030 Type 010 with pj_ack=11 on the first ack cycle → FSM IDLE, no error; pj_tv then dropped in the middle of a type 000 transaction → err_code=4.
REQ-031 Reset asserted during a BUSY type 101 transaction → all outputs 0 and no error pulse after reset is released.
